// File: rtl/wb_scoreboard.sv
// wb_scoreboard: register-write scoreboard for the 8-bit pipelined core.
// Tracks outstanding register-file writes between issue and writeback and
// stalls issue on read-after-write hazards or per-register count saturation.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   issue_*             decode-stage instruction (operands, destination)
//   wb_regWE, wb_dest   writeback commit from the MEM/WB buffer
//   flush               pipeline squash, clears all tracking
//   issue_stall         combinational hold request for decode
//   issue_fire          combinational, issue_valid & ~issue_stall
//   pending_mask        bit r set while register r has writes in flight
//   inflight            registered total of outstanding writes
//   idle                inflight == 0
//   wb_underflow        sticky: writeback arrived for a register with none pending
module wb_scoreboard #(
    parameter int NUM_REGS = 8,
    parameter int ADDR_W   = 3,
    parameter int CNT_W    = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                issue_valid,
    input  logic [ADDR_W-1:0]   issue_srcA,
    input  logic                issue_srcA_use,
    input  logic [ADDR_W-1:0]   issue_srcB,
    input  logic                issue_srcB_use,
    input  logic                issue_regWE,
    input  logic [ADDR_W-1:0]   issue_dest,
    input  logic                wb_regWE,
    input  logic [ADDR_W-1:0]   wb_dest,
    input  logic                flush,
    output logic                issue_stall,
    output logic                issue_fire,
    output logic [NUM_REGS-1:0] pending_mask,
    output logic [4:0]          inflight,
    output logic                idle,
    output logic                wb_underflow
);

    logic [CNT_W-1:0] count [NUM_REGS];

    logic haz_a, haz_b, sat;
    logic do_set, do_clr, do_uf;

    // Hazard terms use registered counts only, so wb_* never reaches issue_stall.
    always_comb begin
        haz_a       = issue_srcA_use && (count[issue_srcA] != '0);
        haz_b       = issue_srcB_use && (count[issue_srcB] != '0);
        sat         = issue_regWE && (count[issue_dest] == '1);
        issue_stall = flush || (issue_valid && (haz_a || haz_b || sat));
        issue_fire  = issue_valid && !issue_stall;
    end

    // Writebacks are ignored entirely while flushing (no retire, no underflow).
    always_comb begin
        do_set = issue_fire && issue_regWE;
        do_clr = !flush && wb_regWE && (count[wb_dest] != '0);
        do_uf  = !flush && wb_regWE && (count[wb_dest] == '0);
    end

    always_comb begin
        pending_mask = '0;
        for (int unsigned r = 0; r < NUM_REGS; r++) begin
            pending_mask[r] = (count[r] != '0);
        end
        idle = (inflight == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
                count[r] <= '0;
            end
            inflight     <= '0;
            wb_underflow <= 1'b0;
        end else if (flush) begin
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
                count[r] <= '0;
            end
            inflight <= '0;
        end else begin
            // A set and a clear hitting the same register cancel out.
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
                if (do_set && issue_dest == ADDR_W'(r) &&
                    !(do_clr && wb_dest == ADDR_W'(r))) begin
                    count[r] <= count[r] + CNT_W'(1);
                end else if (do_clr && wb_dest == ADDR_W'(r) &&
                             !(do_set && issue_dest == ADDR_W'(r))) begin
                    count[r] <= count[r] - CNT_W'(1);
                end
            end
            if (do_set && !do_clr) begin
                inflight <= inflight + 5'd1;
            end else if (do_clr && !do_set) begin
                inflight <= inflight - 5'd1;
            end
            if (do_uf) begin
                wb_underflow <= 1'b1;
            end
        end
    end

endmodule
